// File: rtl/snd_mixer_n.sv
// rtl/snd_mixer_n.sv - N-channel gain mixer with saturation; optional DC blocker under SND_MIXER_DC_BLOCK_EN
module snd_mixer_n #(
    parameter int CHANNELS = 4,
    parameter int GAIN_W   = 12,
    parameter int FRAC     = 7
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     sample_ce,
    input  logic [16*CHANNELS-1:0]   ch_in,
    input  logic [CHANNELS-1:0]      ch_en,
    input  logic                     gain_wr,
    input  logic [2:0]               gain_sel,
    input  logic [GAIN_W-1:0]        gain_din,
    output logic signed [15:0]       sample,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     clip,
    output logic                     overrun,
    input  logic                     flags_clr
);

    localparam int ACC_W  = 16 + GAIN_W + 1 + $clog2(CHANNELS + 1);
    localparam int PROD_W = 17 + GAIN_W;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << FRAC);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

    state_t state_q, state_d;

    logic [GAIN_W-1:0]        gain_reg [CHANNELS];
    logic [GAIN_W-1:0]        sh_gain  [CHANNELS];
    logic signed [15:0]       sh_ch    [CHANNELS];
    logic [CHANNELS-1:0]      sh_en;
    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic                     last_ch;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [15:0]       sat_val;
    logic                     sat_hit;
    logic                     out_hit;
    logic                     dc_hit;

    assign last_ch = (idx == IDX_W'(CHANNELS - 1));
    assign busy    = (state_q != S_IDLE);
    assign shifted = acc >>> FRAC;
    assign out_hit = sat_hit && (state_q == S_OUTPUT);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (sample_ce) state_d = S_ACCUM;
            S_ACCUM:  if (last_ch)   state_d = S_OUTPUT;
            S_OUTPUT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Gain is unsigned: zero-extend before the signed multiply.
    always_comb begin
        prod = PROD_W'(sh_ch[idx]) * PROD_W'($signed({1'b0, sh_gain[idx]}));
        if (!sh_en[idx]) prod = '0;
    end

    always_comb begin
        sat_hit = 1'b0;
        sat_val = shifted[15:0];
        if (shifted > SAT_HI) begin
            sat_val = 16'sh7fff;
            sat_hit = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_val = 16'sh8000;
            sat_hit = 1'b1;
        end
    end

`ifdef SND_MIXER_DC_BLOCK_EN
    logic signed [15:0] dc_x, x_prev, y_prev, dc_sat;
    logic signed [17:0] dc_sum;
    logic               dc_pend;

    assign dc_sum = 18'(dc_x) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> 8);

    always_comb begin
        dc_hit = 1'b0;
        dc_sat = dc_sum[15:0];
        if (dc_sum > 18'sd32767) begin
            dc_sat = 16'sh7fff;
            dc_hit = dc_pend;
        end else if (dc_sum < -18'sd32768) begin
            dc_sat = 16'sh8000;
            dc_hit = dc_pend;
        end
    end
`else
    assign dc_hit = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            idx          <= '0;
            sh_en        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                gain_reg[k] <= UNITY;
                sh_gain[k]  <= UNITY;
                sh_ch[k]    <= '0;
            end
`ifdef SND_MIXER_DC_BLOCK_EN
            dc_x    <= '0;
            x_prev  <= '0;
            y_prev  <= '0;
            dc_pend <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            if (gain_wr && (32'(gain_sel) < CHANNELS))
                gain_reg[gain_sel[IDX_W-1:0]] <= gain_din;
            case (state_q)
                S_IDLE: if (sample_ce) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        sh_ch[k]   <= ch_in[16*k +: 16];
                        sh_gain[k] <= gain_reg[k];
                    end
                    sh_en <= ch_en;
                    acc   <= '0;
                    idx   <= '0;
                end
                S_ACCUM: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                end
                S_OUTPUT: begin
`ifdef SND_MIXER_DC_BLOCK_EN
                    dc_x    <= sat_val;
                    dc_pend <= 1'b1;
`else
                    sample       <= sat_val;
                    sample_valid <= 1'b1;
`endif
                end
                default: ;
            endcase
`ifdef SND_MIXER_DC_BLOCK_EN
            // The filter stage runs independently so a back-to-back frame can already be accumulating.
            if (dc_pend) begin
                dc_pend      <= 1'b0;
                sample       <= dc_sat;
                sample_valid <= 1'b1;
                x_prev       <= dc_x;
                y_prev       <= dc_sat;
            end
`endif
        end
    end

    // Set events win over a simultaneous clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (out_hit || dc_hit) clip <= 1'b1;
            else if (flags_clr)    clip <= 1'b0;
            if (sample_ce && busy) overrun <= 1'b1;
            else if (flags_clr)    overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snd_mixer_n.sv
// tb/tb_snd_mixer_n.sv - randomized self-checking bench for snd_mixer_n against an arithmetic model
module tb_snd_mixer_n;
    localparam int CH = 4;
    localparam int GW = 12;
    localparam int FR = 7;
`ifdef SND_MIXER_DC_BLOCK_EN
    localparam int LAT = CH + 2;
`else
    localparam int LAT = CH + 1;
`endif

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              sample_ce = 1'b0;
    logic [16*CH-1:0]  ch_in = '0;
    logic [CH-1:0]     ch_en = '0;
    logic              gain_wr = 1'b0;
    logic [2:0]        gain_sel = '0;
    logic [GW-1:0]     gain_din = '0;
    logic [15:0]       sample;
    logic              sample_valid, busy, clip, overrun;
    logic              flags_clr = 1'b0;

    snd_mixer_n #(.CHANNELS(CH), .GAIN_W(GW), .FRAC(FR)) dut (
        .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce), .ch_in(ch_in),
        .ch_en(ch_en), .gain_wr(gain_wr), .gain_sel(gain_sel), .gain_din(gain_din),
        .sample(sample), .sample_valid(sample_valid), .busy(busy), .clip(clip),
        .overrun(overrun), .flags_clr(flags_clr)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0;
    int          errors = 0;
    shortint     m_ch [CH];
    logic [CH-1:0] m_en;
    int          m_gain [CH];
    longint      m_xp, m_yp;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic longint sat16(input longint v, inout bit c);
        if (v > 32767) begin c = 1; return 32767; end
        if (v < -32768) begin c = 1; return -32768; end
        return v;
    endfunction

    function automatic void model_frame(output logic [15:0] s, output bit c);
        longint acc, v, y;
        acc = 0;
        c = 0;
        for (int k = 0; k < CH; k++)
            if (m_en[k]) acc += longint'(m_ch[k]) * longint'(m_gain[k]);
        v = sat16(acc >>> FR, c);
`ifdef SND_MIXER_DC_BLOCK_EN
        y = sat16(v - m_xp + m_yp - (m_yp >>> 8), c);
        m_xp = v;
        m_yp = y;
        v = y;
`else
        y = v;
`endif
        s = 16'(v);
    endfunction

    task automatic model_reset;
        for (int k = 0; k < CH; k++) m_gain[k] = 1 << FR;
        m_xp = 0;
        m_yp = 0;
    endtask

    task automatic apply_inputs;
        for (int k = 0; k < CH; k++) ch_in[16*k +: 16] = 16'(m_ch[k]);
        ch_en = m_en;
    endtask

    task automatic write_gain(input int sel, input int val);
        gain_wr  = 1'b1;
        gain_sel = 3'(sel);
        gain_din = GW'(val);
        tick;
        gain_wr = 1'b0;
        if (sel < CH) m_gain[sel] = val;
    endtask

    task automatic clear_flags;
        flags_clr = 1'b1;
        tick;
        flags_clr = 1'b0;
    endtask

    task automatic run_frame(output int lat, output logic [15:0] smp, output logic busy_mid);
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        busy_mid = busy;
        lat = -1;
        smp = 'x;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (sample_valid) begin
                lat = n;
                smp = sample;
                break;
            end
        end
    endtask

    task automatic check_frame(input string name);
        logic [15:0] exp_s, got_s;
        bit          exp_c;
        int          lat;
        logic        bm;
        clear_flags;
        model_frame(exp_s, exp_c);
        run_frame(lat, got_s, bm);
        checks += 4;
        if (lat !== LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); end
        if (got_s !== exp_s) begin errors++; $display("FAIL %s sample: got %h want %h", name, got_s, exp_s); end
        if (clip !== exp_c) begin errors++; $display("FAIL %s clip: got %b want %b", name, clip, exp_c); end
        if (bm !== 1'b1) begin errors++; $display("FAIL %s busy during mix: got %b want 1", name, bm); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks += 5;
        if (sample !== 16'h0) begin errors++; $display("FAIL reset sample: got %h want 0000", sample); end
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset sample_valid: got %b want 0", sample_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (clip !== 1'b0) begin errors++; $display("FAIL reset clip: got %b want 0", clip); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
        reset = 1'b0;
        model_reset;
        tick;
    endtask

    task automatic test_unity;
        m_ch = '{1000, 0, 0, 0};
        m_en = '1;
        check_frame("unity");
        tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL unity busy after: got %b want 0", busy); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < CH; k++) write_gain(k, $urandom_range(0, 400));
            for (int k = 0; k < CH; k++) m_ch[k] = shortint'($urandom);
            m_en = CH'($urandom_range(0, (1 << CH) - 1));
            check_frame("random");
        end
    endtask

    task automatic test_sat_pos;
        for (int k = 0; k < CH; k++) begin write_gain(k, 256); m_ch[k] = shortint'(16'h7000); end
        m_en = '1;
        check_frame("sat_pos");
        clear_flags;
        checks++;
        if (clip !== 1'b0) begin errors++; $display("FAIL sat_pos clip cleared: got %b want 0", clip); end
    endtask

    task automatic test_sat_neg;
        for (int k = 0; k < CH; k++) begin write_gain(k, 255); m_ch[k] = shortint'(16'h9000); end
        m_en = '1;
        check_frame("sat_neg");
    endtask

    task automatic test_overrun;
        logic [15:0] exp_s, got_s;
        bit          exp_c;
        int          pulses, first;
        for (int k = 0; k < CH; k++) write_gain(k, 128);
        m_ch = '{111, -222, 333, 44};
        m_en = '1;
        clear_flags;
        model_frame(exp_s, exp_c);
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        pulses = 0;
        first = -1;
        got_s = 'x;
        for (int n = 1; n <= 15; n++) begin
            if (n == 2) begin m_ch = '{5000, 5000, 5000, 5000}; apply_inputs; sample_ce = 1'b1; end
            if (n == 3) sample_ce = 1'b0;
            tick;
            if (sample_valid) begin
                pulses++;
                if (first < 0) begin first = n; got_s = sample; end
            end
        end
        checks += 4;
        if (pulses !== 1) begin errors++; $display("FAIL overrun pulses: got %0d want 1", pulses); end
        if (first !== LAT) begin errors++; $display("FAIL overrun latency: got %0d want %0d", first, LAT); end
        if (got_s !== exp_s) begin errors++; $display("FAIL overrun sample: got %h want %h", got_s, exp_s); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun flag: got %b want 1", overrun); end
        clear_flags;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun cleared: got %b want 0", overrun); end
    endtask

    task automatic test_gain_midframe;
        logic [15:0] exp_s, got_s;
        bit          exp_c;
        int          lat;
        for (int k = 0; k < CH; k++) write_gain(k, 128);
        m_ch = '{0, 500, 0, 0};
        m_en = '1;
        model_frame(exp_s, exp_c);
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        lat = -1;
        got_s = 'x;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) begin gain_wr = 1'b1; gain_sel = 3'd1; gain_din = '0; end
            if (n == 3) begin gain_sel = 3'd6; gain_din = '0; end
            if (n == 4) gain_wr = 1'b0;
            tick;
            if (sample_valid) begin lat = n; got_s = sample; break; end
        end
        gain_wr = 1'b0;
        m_gain[1] = 0;
        checks += 2;
        if (lat !== LAT) begin errors++; $display("FAIL gain_mid latency: got %0d want %0d", lat, LAT); end
        if (got_s !== exp_s) begin errors++; $display("FAIL gain_mid sample: got %h want %h", got_s, exp_s); end
        m_ch = '{300, 500, 200, 0};
        check_frame("gain_next");
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp1, exp2, got1, got2;
        bit          c1, c2;
        int          lat2;
        clear_flags;
        m_ch = '{1200, -300, 77, 900};
        m_en = '1;
        model_frame(exp1, c1);
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        got1 = 'x;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (sample_valid) begin got1 = sample; break; end
        end
        m_ch = '{-1500, 250, 0, 31};
        model_frame(exp2, c2);
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        lat2 = -1;
        got2 = 'x;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (sample_valid) begin lat2 = n; got2 = sample; break; end
        end
        checks += 4;
        if (got1 !== exp1) begin errors++; $display("FAIL b2b first sample: got %h want %h", got1, exp1); end
        if (got2 !== exp2) begin errors++; $display("FAIL b2b second sample: got %h want %h", got2, exp2); end
        if (lat2 !== LAT) begin errors++; $display("FAIL b2b second latency: got %0d want %0d", lat2, LAT); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b overrun: got %b want 0", overrun); end
    endtask

    task automatic test_reset_midframe;
        int pulses;
        m_ch = '{3000, 3000, 3000, 3000};
        m_en = '1;
        apply_inputs;
        sample_ce = 1'b1;
        tick;
        sample_ce = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_reset;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (sample_valid) pulses++;
        end
        checks += 3;
        if (pulses !== 0) begin errors++; $display("FAIL reset_mid pulses: got %0d want 0", pulses); end
        if (sample !== 16'h0) begin errors++; $display("FAIL reset_mid sample: got %h want 0000", sample); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    endtask

`ifdef SND_MIXER_DC_BLOCK_EN
    task automatic test_dc_block;
        logic [15:0] prev;
        m_ch = '{4000, 0, 0, 0};
        m_en = 4'b0001;
        check_frame("dc_first");
        prev = sample;
        checks++;
        if (prev !== 16'd4000) begin errors++; $display("FAIL dc first value: got %0d want 4000", prev); end
        for (int i = 0; i < 4; i++) begin
            check_frame("dc_decay");
            checks++;
            if ($signed(sample) >= $signed(prev)) begin
                errors++;
                $display("FAIL dc decay: got %0d want below %0d", $signed(sample), $signed(prev));
            end
            prev = sample;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_unity;
        test_random;
        test_sat_pos;
        test_sat_neg;
        test_overrun;
        test_gain_midframe;
        test_back_to_back;
        test_reset_midframe;
`ifdef SND_MIXER_DC_BLOCK_EN
        test_dc_block;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
